hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32I core; drives stall/flush for the IF/ID and ID/EX registers and M-stage hold.
- Detects load-use hazards (D vs E), resolves branch/jump mispredicts at E, generates PC redirect and PHT update, and freezes the pipe on data-memory wait.
- Sits beside the ID/EX register.
- Its E_flush output is that register's flush input.

---
 rtl/rv32_pipe_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 58 +++++
 rtl/hazard_lu_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32I pipeline control slice: hazard FSM
// state encoding, the architectural zero register and the PHT index width.
package rv32_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         PHT_AW_DFLT = 8;

    // Initial load-use countdown: the first bubble is issued from RUN,
    // the remaining ones are counted down in LU_STALL.
    function automatic logic [1:0] lu_cnt_init(input int bubbles);
        lu_cnt_init = 2'(bubbles - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and the resulting
// stall / flush / redirect / PHT-update controls.
// master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if
    import rv32_pipe_pkg::*;
#(
    parameter int PHT_AW = PHT_AW_DFLT
) ();

    logic [4:0]        D_rs1;
    logic [4:0]        D_rs2;
    logic              D_use_rs1;
    logic              D_use_rs2;
    logic [4:0]        E_rd;
    logic              E_wen_rf;
    logic              E_load;
    logic              E_branch;
    logic              E_jump;
    logic              E_predict;
    logic              E_taken;
    logic [PHT_AW-1:0] E_addr_PHT;
    logic [31:0]       E_PC_target;
    logic [31:0]       E_PC_next;
    logic              M_mem_req;
    logic              M_mem_ready;

    logic              F_stall;
    logic              D_stall;
    logic              D_flush;
    logic              E_flush;
    logic              M_stall;
    logic              pc_redirect;
    logic [31:0]       pc_redirect_addr;
    logic              pht_upd_en;
    logic [PHT_AW-1:0] pht_upd_addr;
    logic              pht_upd_taken;

    modport master (
        output D_rs1, D_rs2, D_use_rs1, D_use_rs2,
        output E_rd, E_wen_rf, E_load, E_branch, E_jump, E_predict, E_taken,
        output E_addr_PHT, E_PC_target, E_PC_next,
        output M_mem_req, M_mem_ready,
        input  F_stall, D_stall, D_flush, E_flush, M_stall,
        input  pc_redirect, pc_redirect_addr,
        input  pht_upd_en, pht_upd_addr, pht_upd_taken
    );

    modport slave (
        input  D_rs1, D_rs2, D_use_rs1, D_use_rs2,
        input  E_rd, E_wen_rf, E_load, E_branch, E_jump, E_predict, E_taken,
        input  E_addr_PHT, E_PC_target, E_PC_next,
        input  M_mem_req, M_mem_ready,
        output F_stall, D_stall, D_flush, E_flush, M_stall,
        output pc_redirect, pc_redirect_addr,
        output pht_upd_en, pht_upd_addr, pht_upd_taken
    );

endinterface

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: flags an ID-stage instruction that reads the
// destination of a load currently in EX. Writes to x0 never hazard.
module hazard_lu_detect
    import rv32_pipe_pkg::*;
(
    input  logic [4:0] D_rs1,
    input  logic [4:0] D_rs2,
    input  logic       D_use_rs1,
    input  logic       D_use_rs2,
    input  logic [4:0] E_rd,
    input  logic       E_wen_rf,
    input  logic       E_load,
    output logic       lu_hit
);

    logic rs1_match_s;
    logic rs2_match_s;

    assign rs1_match_s = D_use_rs1 && (D_rs1 == E_rd);
    assign rs2_match_s = D_use_rs2 && (D_rs2 == E_rd);
    assign lu_hit      = E_load && E_wen_rf && (E_rd != REG_ZERO)
                         && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32I core.
// Resolves data-memory wait, branch/jump mispredicts and load-use hazards
// (in that priority) into same-cycle stall/flush/redirect controls.
// Optional build macro: HAZ_PERF_CNT_EN adds stall/flush/mispredict
// performance counters (perf_stall_cyc, perf_flush_cnt, perf_mispred_cnt).
module hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int PHT_AW     = PHT_AW_DFLT
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_mispred_cnt
`endif
);

    localparam logic [1:0] LU_CNT_INIT = lu_cnt_init(LU_BUBBLES);

    hz_state_e         state_r;
    hz_state_e         state_nxt_s;
    logic [1:0]        lu_cnt_r;
    logic [1:0]        lu_cnt_nxt_s;

    logic              mem_wait_s;
    logic              mispredict_s;
    logic              lu_hit_s;

    logic              f_stall_s;
    logic              d_stall_s;
    logic              d_flush_s;
    logic              e_flush_s;
    logic              m_stall_s;
    logic              redirect_s;
    logic [31:0]       redirect_addr_s;
    logic              pht_en_s;
    logic [PHT_AW-1:0] pht_addr_s;
    logic              pht_taken_s;

    hazard_lu_detect u_lu_detect (
        .D_rs1     (hz.D_rs1),
        .D_rs2     (hz.D_rs2),
        .D_use_rs1 (hz.D_use_rs1),
        .D_use_rs2 (hz.D_use_rs2),
        .E_rd      (hz.E_rd),
        .E_wen_rf  (hz.E_wen_rf),
        .E_load    (hz.E_load),
        .lu_hit    (lu_hit_s)
    );

    assign mem_wait_s   = hz.M_mem_req && !hz.M_mem_ready;
    assign mispredict_s = (hz.E_branch && (hz.E_taken != hz.E_predict))
                          || (hz.E_jump && !hz.E_predict);

    // State and load-use countdown register, synchronous reset to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            lu_cnt_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            lu_cnt_r <= lu_cnt_nxt_s;
        end
    end

    // Next-state logic; lu_cnt is nonzero only while a load-use stall is
    // pending, so it doubles as the MEM_WAIT return-state marker.
    always_comb begin
        state_nxt_s  = state_r;
        lu_cnt_nxt_s = lu_cnt_r;
        case (state_r)
            RUN: begin
                if (mem_wait_s) begin
                    state_nxt_s = MEM_WAIT;
                end else if (mispredict_s) begin
                    state_nxt_s = RUN;
                end else if (lu_hit_s && (LU_BUBBLES > 1)) begin
                    state_nxt_s  = LU_STALL;
                    lu_cnt_nxt_s = LU_CNT_INIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LU_STALL: begin
                if (mem_wait_s) begin
                    state_nxt_s = MEM_WAIT;
                end else if (lu_cnt_r <= 2'd1) begin
                    state_nxt_s  = RUN;
                    lu_cnt_nxt_s = 2'd0;
                end else begin
                    lu_cnt_nxt_s = lu_cnt_r - 2'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_wait_s) begin
                    state_nxt_s = MEM_WAIT;
                end else if (lu_cnt_r != 2'd0) begin
                    state_nxt_s = LU_STALL;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s  = RUN;
                lu_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    // Control outputs from current state and hazard inputs; all forced low
    // during reset. In MEM_WAIT the front end stays held through the exit
    // cycle so an instruction held in E is resolved only once back in RUN.
    always_comb begin
        f_stall_s       = 1'b0;
        d_stall_s       = 1'b0;
        d_flush_s       = 1'b0;
        e_flush_s       = 1'b0;
        m_stall_s       = 1'b0;
        redirect_s      = 1'b0;
        redirect_addr_s = 32'h0000_0000;
        pht_en_s        = 1'b0;
        pht_addr_s      = '0;
        pht_taken_s     = 1'b0;
        if (rst) begin
            f_stall_s = 1'b0;
        end else begin
            pht_en_s = hz.E_branch && !mem_wait_s && (state_r != LU_STALL);
            if (pht_en_s) begin
                pht_addr_s  = hz.E_addr_PHT;
                pht_taken_s = hz.E_taken;
            end else begin
                pht_addr_s  = '0;
                pht_taken_s = 1'b0;
            end
            case (state_r)
                RUN: begin
                    if (mem_wait_s) begin
                        f_stall_s = 1'b1;
                        d_stall_s = 1'b1;
                        m_stall_s = 1'b1;
                    end else if (mispredict_s) begin
                        d_flush_s       = 1'b1;
                        e_flush_s       = 1'b1;
                        redirect_s      = 1'b1;
                        redirect_addr_s = (hz.E_taken || hz.E_jump) ? hz.E_PC_target
                                                                    : hz.E_PC_next;
                    end else if (lu_hit_s) begin
                        f_stall_s = 1'b1;
                        d_stall_s = 1'b1;
                        e_flush_s = 1'b1;
                    end else begin
                        f_stall_s = 1'b0;
                    end
                end
                LU_STALL: begin
                    f_stall_s = 1'b1;
                    d_stall_s = 1'b1;
                    if (mem_wait_s) begin
                        m_stall_s = 1'b1;
                    end else begin
                        e_flush_s = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    f_stall_s = 1'b1;
                    d_stall_s = 1'b1;
                    m_stall_s = mem_wait_s;
                end
                default: begin
                    f_stall_s = 1'b0;
                end
            endcase
        end
    end

    assign hz.F_stall          = f_stall_s;
    assign hz.D_stall          = d_stall_s;
    assign hz.D_flush          = d_flush_s;
    assign hz.E_flush          = e_flush_s;
    assign hz.M_stall          = m_stall_s;
    assign hz.pc_redirect      = redirect_s;
    assign hz.pc_redirect_addr = redirect_addr_s;
    assign hz.pht_upd_en       = pht_en_s;
    assign hz.pht_upd_addr     = pht_addr_s;
    assign hz.pht_upd_taken    = pht_taken_s;

`ifdef HAZ_PERF_CNT_EN
    // Free-running wrap-around event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc   <= '0;
            perf_flush_cnt   <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            perf_stall_cyc   <= perf_stall_cyc   + CNT_W'(f_stall_s);
            perf_flush_cnt   <= perf_flush_cnt   + CNT_W'(e_flush_s);
            perf_mispred_cnt <= perf_mispred_cnt + CNT_W'(redirect_s);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LU_BUBBLES=1 and 3)
// share one stimulus stream; a cycle-level behavioural model predicts
// every output. Covers HAZ_PERF_CNT_EN counters when that macro is set.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  d_rs1, d_rs2, e_rd;
    logic        d_use_rs1, d_use_rs2, e_wen_rf, e_load, e_branch, e_jump;
    logic        e_predict, e_taken, m_mem_req, m_mem_ready;
    logic [7:0]  e_addr_pht;
    logic [31:0] e_pc_target, e_pc_next;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl_if #(.PHT_AW(8)) hif1 ();
    hazard_ctrl_if #(.PHT_AW(8)) hif3 ();

    assign hif1.D_rs1 = d_rs1;           assign hif3.D_rs1 = d_rs1;
    assign hif1.D_rs2 = d_rs2;           assign hif3.D_rs2 = d_rs2;
    assign hif1.D_use_rs1 = d_use_rs1;   assign hif3.D_use_rs1 = d_use_rs1;
    assign hif1.D_use_rs2 = d_use_rs2;   assign hif3.D_use_rs2 = d_use_rs2;
    assign hif1.E_rd = e_rd;             assign hif3.E_rd = e_rd;
    assign hif1.E_wen_rf = e_wen_rf;     assign hif3.E_wen_rf = e_wen_rf;
    assign hif1.E_load = e_load;         assign hif3.E_load = e_load;
    assign hif1.E_branch = e_branch;     assign hif3.E_branch = e_branch;
    assign hif1.E_jump = e_jump;         assign hif3.E_jump = e_jump;
    assign hif1.E_predict = e_predict;   assign hif3.E_predict = e_predict;
    assign hif1.E_taken = e_taken;       assign hif3.E_taken = e_taken;
    assign hif1.E_addr_PHT = e_addr_pht; assign hif3.E_addr_PHT = e_addr_pht;
    assign hif1.E_PC_target = e_pc_target; assign hif3.E_PC_target = e_pc_target;
    assign hif1.E_PC_next = e_pc_next;   assign hif3.E_PC_next = e_pc_next;
    assign hif1.M_mem_req = m_mem_req;   assign hif3.M_mem_req = m_mem_req;
    assign hif1.M_mem_ready = m_mem_ready; assign hif3.M_mem_ready = m_mem_ready;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] p1_stall, p1_flush, p1_mis, p3_stall, p3_flush, p3_mis;
`endif

    hazard_ctrl #(.LU_BUBBLES(1), .PHT_AW(8)) u_dut1 (
        .clk (clk), .rst (rst), .hz (hif1)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cyc (p1_stall), .perf_flush_cnt (p1_flush), .perf_mispred_cnt (p1_mis)
`endif
    );

    hazard_ctrl #(.LU_BUBBLES(3), .PHT_AW(8)) u_dut3 (
        .clk (clk), .rst (rst), .hz (hif3)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cyc (p3_stall), .perf_flush_cnt (p3_flush), .perf_mispred_cnt (p3_mis)
`endif
    );

    // Observation vector: {F_stall, D_stall, D_flush, E_flush, M_stall,
    // pc_redirect, pc_redirect_addr[31:0], pht_upd_en, pht_upd_addr[7:0], pht_upd_taken}
    localparam int B_F = 47, B_D = 46, B_DF = 45, B_EF = 44, B_M = 43, B_RD = 42, B_EN = 9;

    logic [47:0] obs1, obs3, exp1, exp3;

    // Model state per instance: k=0 -> LU_BUBBLES=1, k=1 -> LU_BUBBLES=3.
    int          lu_b [2] = '{1, 3};
    int          bubbles_left [2];
    bit          in_wait [2];
    logic [31:0] m_stall_cnt [2];
    logic [31:0] m_flush_cnt [2];
    logic [31:0] m_mis_cnt [2];

    function automatic bit f_mw();
        return m_mem_req && !m_mem_ready;
    endfunction

    function automatic bit f_mp();
        return (e_branch && (e_taken != e_predict)) || (e_jump && !e_predict);
    endfunction

    function automatic bit f_lu();
        return e_load && e_wen_rf && (e_rd != 5'd0)
               && ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
    endfunction

    task automatic model_eval(input int k, output logic [47:0] v);
        bit f, d, df, ef, m, rd, en;
        logic [31:0] a;
        bit lu_stalling;
        f = 0; d = 0; df = 0; ef = 0; m = 0; rd = 0; a = 32'h0;
        lu_stalling = !in_wait[k] && (bubbles_left[k] > 0);
        en = !rst && e_branch && !f_mw() && !lu_stalling;
        if (rst) begin
            en = 0;
        end else if (in_wait[k]) begin
            f = 1; d = 1; m = f_mw();
        end else if (lu_stalling) begin
            f = 1; d = 1;
            if (f_mw()) m = 1; else ef = 1;
        end else if (f_mw()) begin
            f = 1; d = 1; m = 1;
        end else if (f_mp()) begin
            df = 1; ef = 1; rd = 1;
            a = (e_taken || e_jump) ? e_pc_target : e_pc_next;
        end else if (f_lu()) begin
            f = 1; d = 1; ef = 1;
        end
        v = {f, d, df, ef, m, rd, a, en, en ? e_addr_pht : 8'h00, en ? e_taken : 1'b0};
        if (rst) begin
            m_stall_cnt[k] = 32'd0; m_flush_cnt[k] = 32'd0; m_mis_cnt[k] = 32'd0;
        end else begin
            m_stall_cnt[k] += 32'(f); m_flush_cnt[k] += 32'(ef); m_mis_cnt[k] += 32'(rd);
        end
    endtask

    task automatic model_advance(input int k);
        if (rst) begin
            bubbles_left[k] = 0; in_wait[k] = 0;
        end else if (in_wait[k]) begin
            if (!f_mw()) in_wait[k] = 0;
        end else if (bubbles_left[k] > 0) begin
            if (f_mw()) in_wait[k] = 1; else bubbles_left[k]--;
        end else if (f_mw()) begin
            in_wait[k] = 1;
        end else if (!f_mp() && f_lu()) begin
            bubbles_left[k] = lu_b[k] - 1;
        end
    endtask

    // One clock: sample outputs and model mid-cycle, then advance across the edge.
    task automatic step();
        @(negedge clk);
        model_eval(0, exp1);
        model_eval(1, exp3);
        obs1 = {hif1.F_stall, hif1.D_stall, hif1.D_flush, hif1.E_flush, hif1.M_stall,
                hif1.pc_redirect, hif1.pc_redirect_addr, hif1.pht_upd_en,
                hif1.pht_upd_addr, hif1.pht_upd_taken};
        obs3 = {hif3.F_stall, hif3.D_stall, hif3.D_flush, hif3.E_flush, hif3.M_stall,
                hif3.pc_redirect, hif3.pc_redirect_addr, hif3.pht_upd_en,
                hif3.pht_upd_addr, hif3.pht_upd_taken};
        @(posedge clk);
        model_advance(0);
        model_advance(1);
        #1;
    endtask

    task automatic clear_inputs();
        d_rs1 = 5'd0; d_rs2 = 5'd0; e_rd = 5'd0;
        d_use_rs1 = 1'b0; d_use_rs2 = 1'b0; e_wen_rf = 1'b0; e_load = 1'b0;
        e_branch = 1'b0; e_jump = 1'b0; e_predict = 1'b0; e_taken = 1'b0;
        m_mem_req = 1'b0; m_mem_ready = 1'b0; e_addr_pht = 8'h00;
        e_pc_target = 32'h0; e_pc_next = 32'h0;
    endtask

    // lw x5 in E, add x6,x5,x1 in D
    task automatic set_lu_hazard();
        e_load = 1'b1; e_wen_rf = 1'b1; e_rd = 5'd5;
        d_rs1 = 5'd5; d_use_rs1 = 1'b1; d_rs2 = 5'd1; d_use_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        set_lu_hazard();
        e_branch = 1'b1; e_taken = 1'b1; e_pc_target = 32'h100;
        step();
        n_tests++;
        if (obs1 !== 48'h0 || obs3 !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h / %h required 0", obs1, obs3);
        end
        rst = 1'b0;
        clear_inputs();
        step();
        n_tests++;
        if (obs1 !== 48'h0 || obs3 !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h / %h required 0", obs1, obs3);
        end
    endtask

    task automatic test_load_use();
        logic [3:0] f1_pat, f3_pat;
        f1_pat = 4'b0001;
        f3_pat = 4'b0111;
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_lu_hazard(); else clear_inputs();
            step();
            n_tests++;
            if (obs1[B_F] !== f1_pat[c] || obs1[B_D] !== f1_pat[c] || obs1[B_EF] !== f1_pat[c]
                || obs1 !== exp1) begin
                n_fail++;
                $display("FAIL lu_bub1 c%0d: got %h required %h", c, obs1, exp1);
            end
            n_tests++;
            if (obs3[B_F] !== f3_pat[c] || obs3[B_D] !== f3_pat[c] || obs3[B_EF] !== f3_pat[c]
                || obs3 !== exp3) begin
                n_fail++;
                $display("FAIL lu_bub3 c%0d: got %h required %h", c, obs3, exp3);
            end
        end
    endtask

    task automatic test_mispredict();
        logic [47:0] want;
        clear_inputs();
        e_branch = 1'b1; e_predict = 1'b0; e_taken = 1'b1;
        e_pc_target = 32'h0000_0100; e_pc_next = 32'h0000_0020; e_addr_pht = 8'h5A;
        want = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 8'h5A, 1'b1};
        step();
        n_tests++;
        if (obs1 !== want || obs1 !== exp1) begin
            n_fail++;
            $display("FAIL mispredict_bub1: got %h required %h", obs1, want);
        end
        n_tests++;
        if (obs3 !== want || obs3 !== exp3) begin
            n_fail++;
            $display("FAIL mispredict_bub3: got %h required %h", obs3, want);
        end
    endtask

    task automatic test_mispred_with_lu();
        logic [47:0] want;
        clear_inputs();
        set_lu_hazard();
        e_branch = 1'b1; e_predict = 1'b1; e_taken = 1'b0;
        e_pc_target = 32'h0000_0200; e_pc_next = 32'h0000_0044; e_addr_pht = 8'h11;
        want = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 1'b1, 8'h11, 1'b0};
        step();
        n_tests++;
        if (obs1 !== want || obs3 !== want || obs3 !== exp3) begin
            n_fail++;
            $display("FAIL mispred_lu: got %h / %h required %h", obs1, obs3, want);
        end
        clear_inputs();
        step();
        n_tests++;
        if (obs1 !== 48'h0 || obs3 !== 48'h0) begin
            n_fail++;
            $display("FAIL mispred_lu_after: got %h / %h required 0", obs1, obs3);
        end
    endtask

    task automatic test_mem_wait_in_lu();
        // Per cycle {F, D, D_flush, E_flush, M}
        logic [4:0] t3 [9] = '{5'b11010, 5'b11001, 5'b11001, 5'b11001, 5'b11001,
                               5'b11000, 5'b11010, 5'b11010, 5'b00000};
        logic [4:0] t1 [9] = '{5'b11010, 5'b11001, 5'b11001, 5'b11001, 5'b11001,
                               5'b11000, 5'b00000, 5'b00000, 5'b00000};
        clear_inputs();
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            if (c == 0) set_lu_hazard();
            if (c >= 1 && c <= 4) begin
                m_mem_req = 1'b1; m_mem_ready = 1'b0; e_branch = 1'b1;
            end
            if (c == 5) begin
                m_mem_req = 1'b1; m_mem_ready = 1'b1;
            end
            step();
            n_tests++;
            if (obs3[47:43] !== t3[c] || obs3[B_EN] !== 1'b0 || obs3 !== exp3) begin
                n_fail++;
                $display("FAIL memwait_lu_bub3 c%0d: got %h required ctl %b model %h",
                         c, obs3, t3[c], exp3);
            end
            n_tests++;
            if (obs1[47:43] !== t1[c] || obs1[B_EN] !== 1'b0 || obs1 !== exp1) begin
                n_fail++;
                $display("FAIL memwait_lu_bub1 c%0d: got %h required ctl %b model %h",
                         c, obs1, t1[c], exp1);
            end
        end
    endtask

    task automatic test_rst_mid_wait();
        clear_inputs();
        set_lu_hazard();
        step();
        clear_inputs();
        m_mem_req = 1'b1; m_mem_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_tests++;
        if (obs1 !== 48'h0 || obs3 !== 48'h0) begin
            n_fail++;
            $display("FAIL rst_in_wait: got %h / %h required 0", obs1, obs3);
        end
        rst = 1'b0;
        clear_inputs();
        step();
        n_tests++;
        if (obs1 !== 48'h0 || obs3 !== 48'h0 || obs3 !== exp3) begin
            n_fail++;
            $display("FAIL rst_no_residual: got %h / %h required 0", obs1, obs3);
        end
`ifdef HAZ_PERF_CNT_EN
        n_tests++;
        if ({p1_stall, p1_flush, p1_mis, p3_stall, p3_flush, p3_mis} !== 192'h0) begin
            n_fail++;
            $display("FAIL perf_after_rst: got %0d %0d %0d %0d %0d %0d required 0",
                     p1_stall, p1_flush, p1_mis, p3_stall, p3_flush, p3_mis);
        end
`endif
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 59) == 0);
            d_rs1       = 5'($urandom_range(0, 3));
            d_rs2       = 5'($urandom_range(0, 3));
            e_rd        = 5'($urandom_range(0, 3));
            d_use_rs1   = 1'($urandom_range(0, 1));
            d_use_rs2   = 1'($urandom_range(0, 1));
            e_wen_rf    = ($urandom_range(0, 3) != 0);
            e_load      = 1'($urandom_range(0, 1));
            e_branch    = ($urandom_range(0, 2) == 0);
            e_jump      = ($urandom_range(0, 5) == 0);
            e_predict   = 1'($urandom_range(0, 1));
            e_taken     = 1'($urandom_range(0, 1));
            e_addr_pht  = 8'($urandom);
            e_pc_target = $urandom;
            e_pc_next   = $urandom;
            m_mem_req   = ($urandom_range(0, 3) == 0);
            m_mem_ready = ($urandom_range(0, 2) == 0);
            step();
            n_tests++;
            if (obs1 !== exp1 || obs3 !== exp3) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random c%0d: got %h / %h required %h / %h",
                             c, obs1, obs3, exp1, exp3);
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf();
        n_tests++;
        if (p1_stall !== m_stall_cnt[0] || p1_flush !== m_flush_cnt[0] || p1_mis !== m_mis_cnt[0]
            || p3_stall !== m_stall_cnt[1] || p3_flush !== m_flush_cnt[1] || p3_mis !== m_mis_cnt[1]) begin
            n_fail++;
            $display("FAIL perf_counts: got %0d %0d %0d %0d %0d %0d required %0d %0d %0d %0d %0d %0d",
                     p1_stall, p1_flush, p1_mis, p3_stall, p3_flush, p3_mis,
                     m_stall_cnt[0], m_flush_cnt[0], m_mis_cnt[0],
                     m_stall_cnt[1], m_flush_cnt[1], m_mis_cnt[1]);
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < 2; k++) begin
            bubbles_left[k] = 0; in_wait[k] = 0;
            m_stall_cnt[k] = 32'd0; m_flush_cnt[k] = 32'd0; m_mis_cnt[k] = 32'd0;
        end
        clear_inputs();
        test_reset();
        test_load_use();
        test_mispredict();
        test_mispred_with_lu();
        test_mem_wait_in_lu();
        test_rst_mid_wait();
        test_random();
        step();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
